// File: rtl/shr_arb_pkg.sv
// Shared encodings for the two-requester SHR arbiter.
package shr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/shr_arbiter_if.sv
// Request/response bundle between the two issuers (master) and the arbiter (slave).
interface shr_arbiter_if #(
    parameter int DATAWIDTH = 8
);
    localparam int SHAMTW = $clog2(DATAWIDTH);

    logic                 req0_valid;
    logic                 req1_valid;
    logic                 req0_ready;
    logic                 req1_ready;
    logic [DATAWIDTH-1:0] req0_a;
    logic [DATAWIDTH-1:0] req1_a;
    logic [SHAMTW-1:0]    req0_sh_amt;
    logic [SHAMTW-1:0]    req1_sh_amt;
    logic                 rsp0_valid;
    logic                 rsp1_valid;
    logic                 rsp0_ready;
    logic                 rsp1_ready;
    logic [DATAWIDTH-1:0] rsp_d;
    logic                 busy;

    modport master (
        output req0_valid, req1_valid, req0_a, req1_a, req0_sh_amt, req1_sh_amt,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_d, busy
    );

    modport slave (
        input  req0_valid, req1_valid, req0_a, req1_a, req0_sh_amt, req1_sh_amt,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_d, busy
    );

endinterface

// File: rtl/SHR.sv
// Logical right shift, zero fill; amounts >= DATAWIDTH yield zero.
// Latency: combinational. Backpressure: none.
module SHR #(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0]         a_i,
    input  logic [$clog2(DATAWIDTH)-1:0] sh_i,
    output logic [DATAWIDTH-1:0]         d_o
);

    assign d_o = a_i >> sh_i;

endmodule

// File: rtl/shr_arbiter.sv
// Round-robin share of one SHR between two requesters; captures operands, returns registered result.
// Latency: accept edge T, result valid from edge T+1 (IDLE/SHIFT/RESP, one op per 3 cycles minimum).
// Backpressure: a held-off response parks the FSM in RESP; request readys stay low until it drains.
module shr_arbiter
    import shr_arb_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic          Clk,
    input  logic          Rst,
    shr_arbiter_if.slave  bus
);

    localparam int SHAMTW = $clog2(DATAWIDTH);

    state_t               state_q;
    logic                 last_grant_q;
    logic                 id_q;
    logic [DATAWIDTH-1:0] a_q;
    logic [SHAMTW-1:0]    sh_q;
    logic [DATAWIDTH-1:0] d_q;
    logic                 rsp0_valid_q;
    logic                 rsp1_valid_q;
    logic                 busy_q;

    logic                 idle;
    logic                 gnt0;
    logic                 gnt1;
    logic                 rsp_take;
    logic [DATAWIDTH-1:0] shr_d;

    // On contention the requester that did not win last time is served.
    assign idle     = (state_q == IDLE);
    assign gnt0     = idle && bus.req0_valid && (!bus.req1_valid || (last_grant_q == REQ1));
    assign gnt1     = idle && bus.req1_valid && (!bus.req0_valid || (last_grant_q == REQ0));
    assign rsp_take = (id_q == REQ0) ? bus.rsp0_ready : bus.rsp1_ready;

    // Readys are masked while reset is asserted so nothing appears accepted.
    assign bus.req0_ready = Rst & gnt0;
    assign bus.req1_ready = Rst & gnt1;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp_d      = d_q;
    assign bus.busy       = busy_q;

    SHR #(
        .DATAWIDTH (DATAWIDTH)
    ) u_shr (
        .a_i  (a_q),
        .sh_i (sh_q),
        .d_o  (shr_d)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= IDLE;
            last_grant_q <= REQ1;
            id_q         <= REQ0;
            a_q          <= '0;
            sh_q         <= '0;
            d_q          <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        a_q     <= gnt1 ? bus.req1_a : bus.req0_a;
                        sh_q    <= gnt1 ? bus.req1_sh_amt : bus.req0_sh_amt;
                        id_q    <= gnt1 ? REQ1 : REQ0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    d_q          <= shr_d;
                    rsp0_valid_q <= (id_q == REQ0);
                    rsp1_valid_q <= (id_q == REQ1);
                    state_q      <= RESP;
                end
                RESP: begin
                    if (rsp_take) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        last_grant_q <= id_q;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shr_arbiter.sv
// Directed bench for shr_arbiter: an 8-bit instance for arbitration/timing, a 5-bit one for odd widths.
module tb_shr_arbiter;

    logic Clk = 1'b0;
    logic Rst;
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    shr_arbiter_if #(.DATAWIDTH(8)) b8 ();
    shr_arbiter_if #(.DATAWIDTH(5)) b5 ();

    shr_arbiter #(.DATAWIDTH(8)) u8 (.Clk(Clk), .Rst(Rst), .bus(b8.slave));
    shr_arbiter #(.DATAWIDTH(5)) u5 (.Clk(Clk), .Rst(Rst), .bus(b5.slave));

    task automatic idle_inputs();
        b8.req0_valid = 1'b0; b8.req1_valid = 1'b0;
        b8.req0_a = '0; b8.req1_a = '0; b8.req0_sh_amt = '0; b8.req1_sh_amt = '0;
        b8.rsp0_ready = 1'b0; b8.rsp1_ready = 1'b0;
        b5.req0_valid = 1'b0; b5.req1_valid = 1'b0;
        b5.req0_a = '0; b5.req1_a = '0; b5.req0_sh_amt = '0; b5.req1_sh_amt = '0;
        b5.rsp0_ready = 1'b0; b5.rsp1_ready = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            b8.req0_valid = 1'($urandom); b8.req1_valid = 1'($urandom);
            b8.req0_a = 8'($urandom); b8.req1_a = 8'($urandom);
            b8.req0_sh_amt = 3'($urandom); b8.req1_sh_amt = 3'($urandom);
            b8.rsp0_ready = 1'($urandom); b8.rsp1_ready = 1'($urandom);
            b5.req0_valid = 1'($urandom); b5.req1_valid = 1'($urandom);
            b5.req0_a = 5'($urandom); b5.req1_a = 5'($urandom);
            b5.rsp0_ready = 1'($urandom); b5.rsp1_ready = 1'($urandom);
            #1;
            checks++;
            if ({b8.req0_ready, b8.req1_ready, b8.rsp0_valid, b8.rsp1_valid, b8.busy} !== 5'b0) begin
                errors++;
                $display("FAIL reset_ctrl8: got r0r1v0v1busy=%b expected 00000",
                         {b8.req0_ready, b8.req1_ready, b8.rsp0_valid, b8.rsp1_valid, b8.busy});
            end
            checks++;
            if (b8.rsp_d !== 8'h00) begin
                errors++;
                $display("FAIL reset_rsp_d8: got %h expected 00", b8.rsp_d);
            end
            checks++;
            if ({b5.req0_ready, b5.req1_ready, b5.rsp0_valid, b5.rsp1_valid, b5.busy, b5.rsp_d} !== 10'b0) begin
                errors++;
                $display("FAIL reset_all5: got %b expected 0",
                         {b5.req0_ready, b5.req1_ready, b5.rsp0_valid, b5.rsp1_valid, b5.busy, b5.rsp_d});
            end
        end
        @(negedge Clk);
        idle_inputs();
        Rst = 1'b1;
        #1;
        checks++;
        if ({b8.busy, b8.req0_ready, b8.req1_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release_idle: got busy/r0/r1=%b expected 000",
                     {b8.busy, b8.req0_ready, b8.req1_ready});
        end
        b8.req0_valid = 1'b1;
        #1;
        checks++;
        if (b8.req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_grant: got req0_ready=%b expected 1", b8.req0_ready);
        end
        b8.req0_valid = 1'b0;
    endtask

    task automatic test_single();
        @(negedge Clk);
        b8.req0_valid = 1'b1; b8.req0_a = 8'hB4; b8.req0_sh_amt = 3'd3;
        #1;
        checks++;
        if ({b8.req0_ready, b8.req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL single_ready: got r0r1=%b expected 10", {b8.req0_ready, b8.req1_ready});
        end
        @(negedge Clk);
        b8.req0_valid = 1'b0;
        #1;
        checks++;
        if ({b8.busy, b8.rsp0_valid, b8.rsp1_valid} !== 3'b100) begin
            errors++;
            $display("FAIL single_shift: got busy/v0/v1=%b expected 100",
                     {b8.busy, b8.rsp0_valid, b8.rsp1_valid});
        end
        @(negedge Clk);
        #1;
        checks++;
        if ({b8.rsp0_valid, b8.rsp1_valid, b8.rsp_d} !== {2'b10, 8'h16}) begin
            errors++;
            $display("FAIL single_resp: got v0=%b v1=%b d=%h expected v0=1 v1=0 d=16",
                     b8.rsp0_valid, b8.rsp1_valid, b8.rsp_d);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            #1;
            checks++;
            if ({b8.rsp0_valid, b8.rsp1_valid, b8.rsp_d} !== {2'b10, 8'h16}) begin
                errors++;
                $display("FAIL single_hold%0d: got v0=%b v1=%b d=%h expected v0=1 v1=0 d=16",
                         i, b8.rsp0_valid, b8.rsp1_valid, b8.rsp_d);
            end
        end
        b8.rsp0_ready = 1'b1;
        @(negedge Clk);
        b8.rsp0_ready = 1'b0;
        #1;
        checks++;
        if ({b8.rsp0_valid, b8.busy, b8.rsp_d} !== {2'b00, 8'h16}) begin
            errors++;
            $display("FAIL single_release: got v0=%b busy=%b d=%h expected v0=0 busy=0 d=16",
                     b8.rsp0_valid, b8.busy, b8.rsp_d);
        end
    endtask

    task automatic test_contention();
        int   glog[$];
        logic exp_r0, exp_r1, exp_v0, exp_v1;
        Rst = 1'b0;
        b8.req0_valid = 1'b1; b8.req0_a = 8'hFF; b8.req0_sh_amt = 3'd7;
        b8.req1_valid = 1'b1; b8.req1_a = 8'h80; b8.req1_sh_amt = 3'd0;
        b8.rsp0_ready = 1'b1; b8.rsp1_ready = 1'b1;
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            exp_r0 = (c % 3 == 0) && ((c / 3) % 2 == 0);
            exp_r1 = (c % 3 == 0) && ((c / 3) % 2 == 1);
            exp_v0 = (c % 3 == 2) && ((c / 3) % 2 == 0);
            exp_v1 = (c % 3 == 2) && ((c / 3) % 2 == 1);
            if (b8.req0_ready) glog.push_back(0);
            if (b8.req1_ready) glog.push_back(1);
            checks++;
            if ({b8.req0_ready, b8.req1_ready, b8.rsp0_valid, b8.rsp1_valid} !==
                {exp_r0, exp_r1, exp_v0, exp_v1}) begin
                errors++;
                $display("FAIL contention_c%0d: got r0r1v0v1=%b expected %b", c,
                         {b8.req0_ready, b8.req1_ready, b8.rsp0_valid, b8.rsp1_valid},
                         {exp_r0, exp_r1, exp_v0, exp_v1});
            end
            if (exp_v0) begin
                checks++;
                if (b8.rsp_d !== 8'h01) begin
                    errors++;
                    $display("FAIL contention_d0_c%0d: got %h expected 01", c, b8.rsp_d);
                end
            end
            if (exp_v1) begin
                checks++;
                if (b8.rsp_d !== 8'h80) begin
                    errors++;
                    $display("FAIL contention_d1_c%0d: got %h expected 80", c, b8.rsp_d);
                end
            end
            @(negedge Clk);
        end
        idle_inputs();
        checks++;
        if (glog.size() != 4) begin
            errors++;
            $display("FAIL contention_grant_count: got %0d expected 4", glog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (glog[i] != i % 2) begin
                    errors++;
                    $display("FAIL contention_order%0d: got %0d expected %0d", i, glog[i], i % 2);
                end
            end
        end
    endtask

    task automatic test_npot();
        logic [4:0] va [5];
        logic [2:0] vs [5];
        logic [4:0] vd [5];
        va[0] = 5'b10000; vs[0] = 3'd4; vd[0] = 5'b00001;
        va[1] = 5'b10000; vs[1] = 3'd6; vd[1] = 5'b00000;
        va[2] = 5'b10110; vs[2] = 3'd0; vd[2] = 5'b10110;
        va[3] = 5'b11011; vs[3] = 3'd7; vd[3] = 5'b00000;
        va[4] = 5'b11011; vs[4] = 3'd2; vd[4] = 5'b00110;
        b5.rsp0_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            b5.req0_valid = 1'b1; b5.req0_a = va[i]; b5.req0_sh_amt = vs[i];
            @(negedge Clk);
            b5.req0_valid = 1'b0;
            @(negedge Clk);
            #1;
            checks++;
            if ({b5.rsp0_valid, b5.rsp_d} !== {1'b1, vd[i]}) begin
                errors++;
                $display("FAIL npot_vec%0d: got v0=%b d=%b expected v0=1 d=%b",
                         i, b5.rsp0_valid, b5.rsp_d, vd[i]);
            end
        end
        @(negedge Clk);
        b5.rsp0_ready = 1'b0;
    endtask

    task automatic test_busy_req();
        @(negedge Clk);
        b8.req0_valid = 1'b1; b8.req0_a = 8'h3C; b8.req0_sh_amt = 3'd2;
        @(negedge Clk);
        b8.req0_valid = 1'b0;
        @(negedge Clk);
        #1;
        checks++;
        if ({b8.rsp0_valid, b8.rsp_d} !== {1'b1, 8'h0F}) begin
            errors++;
            $display("FAIL busy_resp: got v0=%b d=%h expected v0=1 d=0f", b8.rsp0_valid, b8.rsp_d);
        end
        b8.req1_valid = 1'b1; b8.req1_a = 8'hAA; b8.req1_sh_amt = 3'd1;
        #1;
        checks++;
        if ({b8.req0_ready, b8.req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL busy_ready: got r0r1=%b expected 00", {b8.req0_ready, b8.req1_ready});
        end
        @(negedge Clk);
        b8.req1_valid = 1'b0;
        b8.rsp0_ready = 1'b1;
        @(negedge Clk);
        b8.rsp0_ready = 1'b0;
        #1;
        checks++;
        if ({b8.rsp0_valid, b8.busy} !== 2'b00) begin
            errors++;
            $display("FAIL busy_drain: got v0=%b busy=%b expected 0 0", b8.rsp0_valid, b8.busy);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            #1;
            checks++;
            if ({b8.busy, b8.rsp1_valid} !== 2'b00) begin
                errors++;
                $display("FAIL busy_not_captured%0d: got busy=%b v1=%b expected 0 0",
                         i, b8.busy, b8.rsp1_valid);
            end
        end
    endtask

    task automatic test_reset_shift();
        @(negedge Clk);
        b8.req1_valid = 1'b1; b8.req1_a = 8'hF0; b8.req1_sh_amt = 3'd4;
        b8.rsp1_ready = 1'b1;
        #1;
        checks++;
        if (b8.req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_shift_accept: got req1_ready=%b expected 1", b8.req1_ready);
        end
        @(negedge Clk);
        b8.req1_valid = 1'b0;
        #1;
        checks++;
        if (b8.busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_shift_inflight: got busy=%b expected 1", b8.busy);
        end
        Rst = 1'b0;
        #1;
        checks++;
        if ({b8.busy, b8.rsp1_valid} !== 2'b00) begin
            errors++;
            $display("FAIL rst_shift_clear: got busy=%b v1=%b expected 0 0", b8.busy, b8.rsp1_valid);
        end
        @(negedge Clk);
        b8.req0_valid = 1'b1; b8.req0_a = 8'h96; b8.req0_sh_amt = 3'd1;
        b8.req1_valid = 1'b1;
        b8.rsp0_ready = 1'b1;
        Rst = 1'b1;
        #1;
        checks++;
        if ({b8.req0_ready, b8.req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rst_shift_first_grant: got r0r1=%b expected 10", {b8.req0_ready, b8.req1_ready});
        end
        for (int c = 1; c < 3; c++) begin
            @(negedge Clk);
            b8.req0_valid = 1'b0; b8.req1_valid = 1'b0;
            #1;
            checks++;
            if ({b8.rsp1_valid, b8.rsp0_valid} !== {1'b0, c == 2}) begin
                errors++;
                $display("FAIL rst_shift_resp_c%0d: got v1=%b v0=%b expected v1=0 v0=%b",
                         c, b8.rsp1_valid, b8.rsp0_valid, c == 2);
            end
        end
        checks++;
        if (b8.rsp_d !== 8'h4B) begin
            errors++;
            $display("FAIL rst_shift_data: got %h expected 4b", b8.rsp_d);
        end
        @(negedge Clk);
        idle_inputs();
    endtask

    initial begin
        Rst = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_npot();
        test_busy_req();
        test_reset_shift();
        repeat (2) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
